// File: rtl/delay_pkg.sv
// Shared types, defaults and window helper for the DELAY pulse period monitor.
package delay_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSync,
        StLocked,
        StFault
    } state_e;

    localparam int unsigned DefN       = 15000;
    localparam int unsigned DefCbits   = 14;
    localparam int unsigned DefTol     = 0;
    localparam int unsigned DefLockCnt = 2;

    // Written as e + tol >= p so that p - tol can never underflow.
    function automatic logic in_window(input int unsigned e, input int unsigned p,
                                       input int unsigned tol);
        return (e + tol >= p) && (e <= p + tol);
    endfunction

endpackage

// File: rtl/delay_interval_cnt.sv
// Elapsed-clock counter: loads 1 the cycle after a pulse, otherwise counts up and saturates.
module delay_interval_cnt #(
    parameter int unsigned W = 15
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= W'(1);
        end else if (!(&r_cnt)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/delay_period_monitor.sv
// Checks the period of the DELAY generator pulse: locks after consecutive good intervals and
// flags early or missing pulses once locked, with a sticky error and a saturating fault count.
module delay_period_monitor
    import delay_pkg::*;
#(
    parameter int unsigned N        = DefN,
    parameter int unsigned CBITS    = DefCbits,
    parameter int unsigned TOL      = DefTol,
    parameter int unsigned LOCK_CNT = DefLockCnt
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sig,
    input  logic             i_clr,
    output logic             o_locked,
    output logic             o_err,
    output logic             o_early,
    output logic             o_miss,
    output logic [CBITS:0]   o_last_period,
    output logic [7:0]       o_fault_count
);

    localparam int unsigned P  = N + 1;
    localparam int unsigned EW = CBITS + 1;
    localparam int unsigned GW = $clog2(LOCK_CNT + 1);

    localparam logic [EW-1:0] LimHi   = EW'(P + TOL);
    localparam logic [GW-1:0] LockTgt = GW'(LOCK_CNT);

    logic [EW-1:0] w_e;
    logic          w_in_win;
    logic          w_timeout;
    logic [GW-1:0] w_good_inc;

    state_e        r_state, w_state_d;
    logic [GW-1:0] r_good, w_good_d;

    logic          r_locked, r_err, r_early, r_miss;
    logic          w_err_d, w_early_d, w_miss_d;
    logic [EW-1:0] r_last_period, w_last_period_d;
    logic [7:0]    r_fault_count, w_fault_count_d;

    delay_interval_cnt #(
        .W(EW)
    ) u_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_load(i_sig),
        .o_cnt (w_e)
    );

    assign w_in_win   = in_window(32'(w_e), P, TOL);
    assign w_timeout  = !i_sig && (w_e == LimHi);
    assign w_good_inc = r_good + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_good  <= '0;
        end else begin
            r_state <= w_state_d;
            r_good  <= w_good_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_good_d  = r_good;
        if (i_clr) begin
            w_state_d = StIdle;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_sig) begin
                        w_state_d = StSync;
                        w_good_d  = '0;
                    end
                end
                StSync: begin
                    if (i_sig) begin
                        if (w_in_win) begin
                            w_good_d = w_good_inc;
                            if (w_good_inc == LockTgt) begin
                                w_state_d = StLocked;
                            end
                        end else begin
                            w_good_d = '0;
                        end
                    end else if (w_timeout) begin
                        w_state_d = StIdle;
                    end
                end
                StLocked: begin
                    // A late pulse cannot reach here: the timeout fires first at P+TOL.
                    if ((i_sig && !w_in_win) || w_timeout) begin
                        w_state_d = StFault;
                    end
                end
                StFault: w_state_d = StFault;
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        w_early_d       = !i_clr && (r_state == StLocked) && i_sig && !w_in_win;
        w_miss_d        = !i_clr && (r_state == StLocked) && w_timeout;
        w_err_d         = i_clr ? 1'b0 : (r_err || w_early_d || w_miss_d);
        w_last_period_d = r_last_period;
        if (!i_clr && i_sig && ((r_state == StSync) || (r_state == StLocked))) begin
            w_last_period_d = w_e;
        end
        w_fault_count_d = r_fault_count;
        if ((w_state_d == StFault) && (r_state != StFault) && (r_fault_count != 8'hFF)) begin
            w_fault_count_d = r_fault_count + 8'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_locked      <= 1'b0;
            r_err         <= 1'b0;
            r_early       <= 1'b0;
            r_miss        <= 1'b0;
            r_last_period <= '0;
            r_fault_count <= '0;
        end else begin
            r_locked      <= (w_state_d == StLocked);
            r_err         <= w_err_d;
            r_early       <= w_early_d;
            r_miss        <= w_miss_d;
            r_last_period <= w_last_period_d;
            r_fault_count <= w_fault_count_d;
        end
    end

    assign o_locked      = r_locked;
    assign o_err         = r_err;
    assign o_early       = r_early;
    assign o_miss        = r_miss;
    assign o_last_period = r_last_period;
    assign o_fault_count = r_fault_count;

endmodule

// File: tb/tb_delay_period_monitor.sv
// Randomized and directed bench for delay_period_monitor: two instances (TOL=0 and TOL=1) are
// driven with the same pulse train and compared every cycle against a pulse-timestamp model.
module tb_delay_period_monitor;

    localparam int N        = 10;
    localparam int P        = N + 1;
    localparam int CBITS    = 4;
    localparam int LOCK_CNT = 2;
    localparam int TolA     = 0;
    localparam int TolB     = 1;

    localparam int MIdle   = 0;
    localparam int MSync   = 1;
    localparam int MLocked = 2;
    localparam int MFault  = 3;

    logic clk = 1'b0;
    logic tb_rst = 1'b1;
    logic tb_sig = 1'b0;
    logic tb_clr = 1'b0;

    logic           locked_w [2];
    logic           err_w    [2];
    logic           early_w  [2];
    logic           miss_w   [2];
    logic [CBITS:0] lp_w     [2];
    logic [7:0]     fc_w     [2];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model state: mode, good count, timestamp of last accepted pulse, expected outputs.
    int m_state [2];
    int m_good  [2];
    int m_last  [2];
    int m_err   [2];
    int m_early [2];
    int m_miss  [2];
    int m_lp    [2];
    int m_fc    [2];

    always #5 clk = ~clk;

    delay_period_monitor #(
        .N(N), .CBITS(CBITS), .TOL(TolA), .LOCK_CNT(LOCK_CNT)
    ) dut_a (
        .i_clk(clk), .i_rst(tb_rst), .i_sig(tb_sig), .i_clr(tb_clr),
        .o_locked(locked_w[0]), .o_err(err_w[0]), .o_early(early_w[0]),
        .o_miss(miss_w[0]), .o_last_period(lp_w[0]), .o_fault_count(fc_w[0])
    );

    delay_period_monitor #(
        .N(N), .CBITS(CBITS), .TOL(TolB), .LOCK_CNT(LOCK_CNT)
    ) dut_b (
        .i_clk(clk), .i_rst(tb_rst), .i_sig(tb_sig), .i_clr(tb_clr),
        .o_locked(locked_w[1]), .o_err(err_w[1]), .o_early(early_w[1]),
        .o_miss(miss_w[1]), .o_last_period(lp_w[1]), .o_fault_count(fc_w[1])
    );

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_fault(input int k);
        m_err[k]   = 1;
        m_state[k] = MFault;
        if (m_fc[k] < 255) m_fc[k]++;
    endtask

    task automatic model_step(input int k, input logic s, input logic c, input logic r,
                              input int tol);
        int el;
        el         = cyc - m_last[k];
        m_early[k] = 0;
        m_miss[k]  = 0;
        if (r) begin
            m_state[k] = MIdle;
            m_good[k]  = 0;
            m_err[k]   = 0;
            m_lp[k]    = 0;
            m_fc[k]    = 0;
        end else if (c) begin
            m_state[k] = MIdle;
            m_err[k]   = 0;
        end else if (m_state[k] == MIdle) begin
            if (s) begin
                m_state[k] = MSync;
                m_good[k]  = 0;
                m_last[k]  = cyc;
            end
        end else if (m_state[k] == MSync) begin
            if (s) begin
                m_lp[k]   = el;
                m_last[k] = cyc;
                if (el >= P - tol && el <= P + tol) begin
                    m_good[k]++;
                    if (m_good[k] == LOCK_CNT) m_state[k] = MLocked;
                end else begin
                    m_good[k] = 0;
                end
            end else if (el == P + tol) begin
                m_state[k] = MIdle;
            end
        end else if (m_state[k] == MLocked) begin
            if (s) begin
                m_lp[k]   = el;
                m_last[k] = cyc;
                if (el < P - tol) begin
                    m_early[k] = 1;
                    model_fault(k);
                end
            end else if (el == P + tol) begin
                m_miss[k] = 1;
                model_fault(k);
            end
        end
    endtask

    task automatic step(input logic s, input logic c, input logic r);
        tb_sig = s;
        tb_clr = c;
        tb_rst = r;
        model_step(0, s, c, r, TolA);
        model_step(1, s, c, r, TolB);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("locked%0d", k), 32'(locked_w[k]), 32'(m_state[k] == MLocked));
            check_eq($sformatf("err%0d", k), 32'(err_w[k]), m_err[k]);
            check_eq($sformatf("early%0d", k), 32'(early_w[k]), m_early[k]);
            check_eq($sformatf("miss%0d", k), 32'(miss_w[k]), m_miss[k]);
            check_eq($sformatf("last_period%0d", k), 32'(lp_w[k]), m_lp[k]);
            check_eq($sformatf("fault_count%0d", k), 32'(fc_w[k]), m_fc[k]);
        end
        cyc++;
    endtask

    // gap-1 quiet cycles then one pulse; with rnd, clr and rst may land on any cycle.
    task automatic send(input int gap, input bit rnd);
        logic c;
        logic r;
        for (int i = 1; i <= gap; i++) begin
            c = rnd && ($urandom_range(0, 39) == 0);
            r = rnd && ($urandom_range(0, 299) == 0);
            step(i == gap, c, r);
        end
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int pick;
        int gap;
        for (int k = 0; k < 2; k++) begin
            m_state[k] = MIdle;
            m_good[k]  = 0;
            m_last[k]  = 0;
            m_err[k]   = 0;
            m_early[k] = 0;
            m_miss[k]  = 0;
            m_lp[k]    = 0;
            m_fc[k]    = 0;
        end
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);

        // Steady period: lock after the third pulse and stay clean.
        send(4, 1'b0);
        send(P, 1'b0);
        send(P, 1'b0);
        check_eq("lock_after_3rd", 32'(locked_w[0]), 32'd1);
        repeat (20) send(P, 1'b0);
        check_eq("steady_last_period", 32'(lp_w[0]), 32'(P));

        // Early pulse at interval 9.
        send(9, 1'b0);
        check_eq("early_pulse", 32'(early_w[0]), 32'd1);
        quiet(5);
        check_eq("early_err_sticky", 32'(err_w[0]), 32'd1);

        // Relock, then pulses stop: miss; later pulses keep err until clr.
        step(1'b0, 1'b1, 1'b0);
        send(3, 1'b0);
        repeat (3) send(P, 1'b0);
        quiet(15);
        repeat (3) send(P, 1'b0);
        check_eq("miss_err_held", 32'(err_w[0]), 32'd1);

        // clr together with a pulse: pulse ignored, three more pulses to relock.
        step(1'b1, 1'b1, 1'b0);
        repeat (2) send(P, 1'b0);
        check_eq("no_lock_after_2", 32'(locked_w[0]), 32'd0);
        send(P, 1'b0);
        check_eq("lock_after_clr", 32'(locked_w[0]), 32'd1);

        // Intervals 11, 7, 11, 11 from a fresh start.
        step(1'b0, 1'b0, 1'b1);
        send(5, 1'b0);
        send(P, 1'b0);
        send(7, 1'b0);
        send(P, 1'b0);
        check_eq("sync_after_7", 32'(locked_w[0]), 32'd0);
        send(P, 1'b0);
        check_eq("lock_after_reset_good", 32'(locked_w[0]), 32'd1);

        // Tolerance: 10, 12, 11 are fine for TOL=1; then 13 times out at 12.
        send(P - 1, 1'b0);
        send(P + 1, 1'b0);
        send(P, 1'b0);
        check_eq("tol1_no_err", 32'(err_w[1]), 32'd0);
        send(P + 2, 1'b0);
        check_eq("tol1_err_after_13", 32'(err_w[1]), 32'd1);

        // Reset mid-period.
        send(4, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check_eq("rst_fault_count", 32'(fc_w[1]), 32'd0);

        // Random pulse trains with occasional clr and rst.
        for (int g = 0; g < 600; g++) begin
            pick = int'($urandom_range(0, 9));
            if (pick <= 3)      gap = P;
            else if (pick == 4) gap = P - 1;
            else if (pick == 5) gap = P + 1;
            else if (pick == 6) gap = int'($urandom_range(1, P - 2));
            else if (pick == 7) gap = int'($urandom_range(P + 2, P + 9));
            else if (pick == 8) gap = int'($urandom_range(P - 1, P + 1));
            else                gap = 25;
            send(gap, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/delay_period_monitor.md
Name: delay_period_monitor

Overview:
- Receive-side checker for the periodic `sig` pulse emitted by the DELAY pulse generator.
- Generator fires one 1-cycle pulse every N+1 clocks. This block measures the interval between pulses, acquires lock after consecutive good periods, and reports early, missing or unexpected pulses.
- Sits beside the generator at subsystem level. Its `err` feeds the same sticky-fault aggregation as the generator's own `err`.

Parameters:
- N, 15000, generator terminal count; expected period P = N+1 clocks.
- CBITS, 14, width of generator counter; internal elapsed counter is CBITS+1 bits.
- TOL, 0, accepted deviation in clocks; window is [P-TOL, P+TOL]. Requires TOL < P.
- LOCK_CNT, 2, consecutive in-window intervals needed to lock.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- sig, input, 1, pulse from generator; 1-cycle high per period.
- clr, input, 1, clears sticky fault and returns the block to IDLE.
- locked, output, 1, high while in LOCKED.
- err, output, 1, sticky; set on any fault in LOCKED, cleared only by rst or clr.
- early, output, 1, 1-cycle pulse: pulse arrived with e < P-TOL while LOCKED.
- miss, output, 1, 1-cycle pulse: no pulse by e == P+TOL while LOCKED.
- last_period, output, CBITS+1, e value of the most recent pulse, saturating.
- fault_count, output, 8, number of FAULT entries, saturating at 255.

Behaviour:
- One clock (`clk`); reset is synchronous and active-high (`rst`).
- All outputs are registered and reflect the cycle-t event at cycle t+1.
- Reset values: locked=0, err=0, early=0, miss=0, last_period=0, fault_count=0, state=IDLE, e=0, good=0.
- Elapsed counter e:
  - Loads 1 on the cycle after any sig=1; otherwise increments.
  - Saturates at all-ones; no wrap.
  - Value sampled in the cycle of a pulse equals the interval since the previous pulse.
- States:
  - IDLE: e ignored. sig=1 -> SYNC, good=0.
  - SYNC:
    - sig=1 with e in window: good+1; if good+1 == LOCK_CNT -> LOCKED.
    - sig=1 out of window: good=0, stay in SYNC, no flags.
    - sig=0 with e == P+TOL: -> IDLE, no flags.
  - LOCKED:
    - sig=1 in window: stay.
    - sig=1 with e < P-TOL: early pulse, err=1, -> FAULT.
    - sig=0 with e == P+TOL: miss pulse, err=1, -> FAULT.
  - FAULT: sig ignored, err held. clr=1 -> IDLE.
  - Each FAULT entry increments fault_count (saturating at 255).
- last_period is updated on every sig=1 outside IDLE/FAULT.
- Priority: rst > clr > sig/timeout.
  - clr in any state -> IDLE, err=0; sig in the same cycle is ignored.
  - fault_count is not cleared by clr.
- A pulse arriving in the same cycle as the timeout condition is not possible: timeout requires sig=0.
- rst mid-period discards all history; the next pulse is treated as the first.
- sig high for 2+ consecutive cycles: the second high cycle has e=1. In LOCKED this is an early fault (unless P-TOL ≤ 1); in SYNC it resets good.

Decomposition:
- Package delay_pkg:
  - state enum {IDLE, SYNC, LOCKED, FAULT}
  - default N/CBITS/TOL/LOCK_CNT localparams
  - helper function in_window(e, P, TOL)
- Sub-module delay_interval_cnt: saturating elapsed counter with load-on-pulse. Top holds the FSM, flags and status registers.

Test Plan (N=10, P=11, TOL=0, LOCK_CNT=2 unless stated):
- Pulses every 11 clocks after rst -> locked=1 one cycle after the 3rd pulse; err=0 for 200 cycles; last_period=11.
- Locked, next pulse at interval 9 -> early=1 for exactly one cycle, err=1 sticky, locked=0, fault_count=1.
- Locked, pulses stop -> miss=1 in the cycle after e reaches 11 without a pulse, err=1; later pulses leave err=1 until clr.
- Intervals 11, 7, 11, 11 after first pulse -> remains in SYNC after the 7 (good reset), locks only after the final two 11s, no err.
- clr asserted with sig in the same cycle while in FAULT -> err=0, state IDLE, that pulse ignored; lock needs 3 further good pulses.
- TOL=1, intervals 10, 12, 11 after lock -> no fault. Interval 13 -> miss. rst mid-period -> all outputs return to reset values the next cycle.
